// File: rtl/y86_pkg.sv
// Shared constants and types for the Y86-64 decode/register-read slice.
package y86_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [XLEN-1:0] val_c;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
    logic [3:0]      src_a;
    logic [3:0]      src_b;
  } de_reg_t;

  localparam de_reg_t NOP_BUBBLE = '{
    icode: INOP, ifun: 4'h0, val_c: '0, val_a: '0, val_b: '0,
    dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE
  };

endpackage

// File: rtl/y86_decode_regread_if.sv
// Decode-stage bus: D inputs, forwarding sources, stall/bubble and E outputs.
interface y86_decode_regread_if;
  import y86_pkg::*;

  logic [3:0]      D_icode, D_ifun, D_rA, D_rB;
  logic [XLEN-1:0] D_valC, D_valP;
  logic [3:0]      e_dstE;
  logic [XLEN-1:0] e_valE;
  logic [3:0]      M_dstE, M_dstM;
  logic [XLEN-1:0] M_valE, m_valM;
  logic [3:0]      W_dstE, W_dstM;
  logic [XLEN-1:0] W_valE, W_valM;
  logic            E_stall, E_bubble;
  logic [3:0]      d_srcA, d_srcB;
  logic [3:0]      E_icode, E_ifun;
  logic [XLEN-1:0] E_valC, E_valA, E_valB;
  logic [3:0]      E_dstE, E_dstM, E_srcA, E_srcB;

  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
    output W_dstE, W_valE, W_dstM, W_valM, E_stall, E_bubble,
    input  d_srcA, d_srcB, E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB
  );

  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
    input  W_dstE, W_valE, W_dstM, W_valM, E_stall, E_bubble,
    output d_srcA, d_srcB, E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB
  );

endinterface

// File: rtl/y86_regfile.sv
// Architectural register file: 15 x XLEN, two write ports (M over E), two async read ports.
module y86_regfile
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      wr_dst_e,
  input  logic [XLEN-1:0] wr_val_e,
  input  logic [3:0]      wr_dst_m,
  input  logic [XLEN-1:0] wr_val_m,
  input  logic [3:0]      rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [3:0]      rd_addr_b,
  output logic [XLEN-1:0] rd_data_b
);

  logic [XLEN-1:0] regs [NREG];

  // Write port M is issued after port E so it wins on a shared destination (popq %rsp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wr_dst_e != RNONE) regs[wr_dst_e] <= wr_val_e;
      if (wr_dst_m != RNONE) regs[wr_dst_m] <= wr_val_m;
    end
  end

  // Combinational reads; RNONE reads as zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != RNONE) rd_data_a = regs[rd_addr_a];
    if (rd_addr_b != RNONE) rd_data_b = regs[rd_addr_b];
  end

endmodule

// File: rtl/y86_decode_regread.sv
// Y86-64 decode stage: register IDs, forwarded operand read, D/E pipeline register.
module y86_decode_regread
  import y86_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  y86_decode_regread_if.slave  dif
);

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [XLEN-1:0]   rf_a, rf_b, val_a, val_b;
  logic [4:0][3:0]   fwd_dst;
  logic [4:0][XLEN-1:0] fwd_val;
  de_reg_t           de_d, de_q;

  y86_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_dst_e  (dif.W_dstE),
    .wr_val_e  (dif.W_valE),
    .wr_dst_m  (dif.W_dstM),
    .wr_val_m  (dif.W_valM),
    .rd_addr_a (src_a),
    .rd_data_a (rf_a),
    .rd_addr_b (src_b),
    .rd_data_b (rf_b)
  );

  // Index 0 is the highest-priority forwarding source.
  assign fwd_dst = {dif.W_dstE, dif.W_dstM, dif.M_dstE, dif.M_dstM, dif.e_dstE};
  assign fwd_val = {dif.W_valE, dif.W_valM, dif.M_valE, dif.m_valM, dif.e_valE};

  function automatic logic [XLEN-1:0] forward(input logic [3:0] src,
                                              input logic [XLEN-1:0] rf,
                                              input logic [4:0][3:0] dsts,
                                              input logic [4:0][XLEN-1:0] vals);
    logic [XLEN-1:0] res;
    logic            hit;
    res = rf;
    hit = 1'b0;
    if (src == RNONE) begin
      res = '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (!hit && dsts[i] == src) begin
          res = vals[i];
          hit = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Register-ID decode from icode.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (dif.D_icode)
      IRRMOVQ: begin src_a = dif.D_rA; dst_e = dif.D_rB; end
      IIRMOVQ: dst_e = dif.D_rB;
      IRMMOVQ: begin src_a = dif.D_rA; src_b = dif.D_rB; end
      IMRMOVQ: begin src_b = dif.D_rB; dst_m = dif.D_rA; end
      IOPQ:    begin src_a = dif.D_rA; src_b = dif.D_rB; dst_e = dif.D_rB; end
      ICALL:   begin src_b = RRSP; dst_e = RRSP; end
      IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      IPUSHQ:  begin src_a = dif.D_rA; src_b = RRSP; dst_e = RRSP; end
      IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = dif.D_rA; end
      default: ;
    endcase
  end

  // Operand selection with five-source forwarding; jXX/call carry valP in valA.
  always_comb begin
    val_b = forward(src_b, rf_b, fwd_dst, fwd_val);
    if (dif.D_icode == IJXX || dif.D_icode == ICALL) val_a = dif.D_valP;
    else                                             val_a = forward(src_a, rf_a, fwd_dst, fwd_val);
    de_d = '{icode: dif.D_icode, ifun: dif.D_ifun, val_c: dif.D_valC,
             val_a: val_a, val_b: val_b, dst_e: dst_e, dst_m: dst_m,
             src_a: src_a, src_b: src_b};
  end

  // D/E pipeline register: bubble beats stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                de_q <= NOP_BUBBLE;
    else if (dif.E_bubble)  de_q <= NOP_BUBBLE;
    else if (!dif.E_stall)  de_q <= de_d;
  end

  assign dif.d_srcA  = src_a;
  assign dif.d_srcB  = src_b;
  assign dif.E_icode = de_q.icode;
  assign dif.E_ifun  = de_q.ifun;
  assign dif.E_valC  = de_q.val_c;
  assign dif.E_valA  = de_q.val_a;
  assign dif.E_valB  = de_q.val_b;
  assign dif.E_dstE  = de_q.dst_e;
  assign dif.E_dstM  = de_q.dst_m;
  assign dif.E_srcA  = de_q.src_a;
  assign dif.E_srcB  = de_q.src_b;

endmodule

// File: doc/y86_decode_regread.md
Name: y86_decode_regread

Overview:
- Decode stage of the pipelined Y86-64 core. It is the read side of the architectural register file that the write-back stage updates.
- Holds the 15x64 register file and derives srcA/srcB/dstE/dstM from the D-stage instruction.
- Reads both operands with five-source forwarding, then latches the result into the D/E pipeline register under stall/bubble control.

Parameters:
- XLEN, 64, datapath width
- NREG, 15, architectural registers (IDs 0..14; ID 0xF = RNONE)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- D_icode  in  4  instruction code in D
- D_ifun  in  4  function code in D
- D_rA  in  4  register field A
- D_rB  in  4  register field B
- D_valC  in  XLEN  constant word
- D_valP  in  XLEN  incremented PC
- e_dstE  in  4  execute-stage destination (after cmov condition)
- e_valE  in  XLEN  execute ALU result
- M_dstE  in  4  memory-stage dstE
- M_valE  in  XLEN  memory-stage valE
- M_dstM  in  4  memory-stage dstM
- m_valM  in  XLEN  memory read data
- W_dstE  in  4  write-back dstE (register write port E)
- W_valE  in  XLEN  write-back valE
- W_dstM  in  4  write-back dstM (register write port M)
- W_valM  in  XLEN  write-back valM
- E_stall  in  1  hold D/E register
- E_bubble  in  1  load NOP into D/E register
- d_srcA  out  4  combinational srcA (to hazard unit)
- d_srcB  out  4  combinational srcB (to hazard unit)
- E_icode, E_ifun  out  4 each  registered
- E_valC, E_valA, E_valB  out  XLEN each  registered
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered

Behaviour:
- Register IDs: RSP=4, RNONE=0xF.
- srcA:
  - rA for icode 2 (rrmovq/cmov), 4, 6, A.
  - RSP for icode 9 and B.
  - Otherwise RNONE.
- srcB:
  - rB for icode 4, 5, 6.
  - RSP for icode 8, 9, A, B.
  - Otherwise RNONE.
- dstE:
  - rB for icode 2, 3, 6.
  - RSP for icode 8, 9, A, B.
  - Otherwise RNONE.
- dstM: rA for icode 5 and B; otherwise RNONE.
- Operand valA:
  - D_valP if icode is 7 or 8.
  - Otherwise the forwarded value of srcA.
- Operand valB: the forwarded value of srcB.
- Forwarding, applied per operand when src != RNONE. Priority, first match wins:
  1. e_dstE -> e_valE
  2. M_dstM -> m_valM
  3. M_dstE -> M_valE
  4. W_dstM -> W_valM
  5. W_dstE -> W_valE
  6. register file
- src == RNONE yields 0.
- Register file writes on rising clk:
  - reg[W_dstE] <= W_valE when W_dstE != RNONE.
  - Then reg[W_dstM] <= W_valM when W_dstM != RNONE.
  - If W_dstE == W_dstM, W_valM wins (popq %rsp semantics).
  - A write to ID 0xF is ignored.
- Reads are combinational. Same-cycle read-after-write is covered by W forwarding; there is no internal bypass.
- D/E register, on rising clk:
  - E_bubble=1 loads the bubble: icode=1 (nop), ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=RNONE.
  - Else E_stall=1 holds the current contents.
  - Else it loads the decoded values. Latency is 1 cycle from the D inputs to the E outputs.
- E_bubble and E_stall asserted together: bubble wins.
- Reset (async, any time):
  - All 15 registers are cleared to 0.
  - The D/E register takes the bubble value.
  - Takes effect immediately, including mid-instruction. Writes in the reset cycle are lost.
- Unknown icode decodes to all RNONE; valA = 0 unless icode is 7 or 8.

Decomposition:
- Package y86_pkg:
  - icode constants (IHALT..IPOPQ)
  - RNONE, RRSP
  - NOP bubble constant
  - XLEN
- Sub-module y86_regfile: 15 x XLEN storage, two write ports with M-over-E priority, two combinational read ports, async reset. The decode/forward/pipeline logic stays in the top module.

Test Plan:
- Reset: assert rst mid-run -> all E outputs show bubble (E_icode=1, E_dstE=0xF); later reads of regs 0..14 return 0.
- Write then read: W_dstE=3, W_valE=0x1234 for one cycle; next cycle D=opq rA=3 rB=3 with no forwarding -> E_valA = E_valB = 0x1234.
- Forward priority: e_dstE=2/e_valE=0xAA, M_dstE=2/M_valE=0xBB, W_dstE=2/W_valE=0xCC, D rrmovq rA=2 -> E_valA=0xAA; drop e -> 0xBB; drop M -> 0xCC.
- popq %rsp dual write: W_dstE=4/W_valE=0x100 and W_dstM=4/W_valM=0x200 -> reg4=0x200. D=popq rA=0 -> srcA=srcB=4, dstE=4, dstM=0.
- call/jxx: D icode=8, D_valP=0x40 -> E_valA=0x40, E_srcB=4, E_dstE=4.
- Stall/bubble: E_stall=1 holds E outputs for 2 cycles; then E_stall=1 and E_bubble=1 together -> nop bubble loaded.
